// File: rtl/prom_ctl_pkg.sv
// Shared types and constants for the 74S472 PROM access arbiter.
package prom_ctl_pkg;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 8;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } prom_state_e;

endpackage

// File: rtl/prom_arb_grant.sv
// Two-way request grant for the PROM arbiter.
// PROM_ARB_RR_EN selects round-robin; otherwise r0 has fixed priority.
module prom_arb_grant (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic xfer0,
  input  logic xfer1,
  output logic grant0,
  output logic grant1
);

  // ptr_r == 0 means r0 wins the next tie.
  logic ptr_r;

  // Tie-break pointer moves past whichever requester just transferred.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= 1'b0;
    end else if (xfer0) begin
      ptr_r <= 1'b1;
    end else if (xfer1) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

`ifdef PROM_ARB_RR_EN
  assign grant0 = req0 & (~req1 | ~ptr_r);
  assign grant1 = req1 & (~req0 |  ptr_r);
`else
  logic unused_ptr_s;
  assign unused_ptr_s = ptr_r;
  assign grant0 = req0;
  assign grant1 = req1 & ~req0;
`endif

endmodule

// File: rtl/prom_access_arbiter.sv
// Shares one async-read 512x8 PROM between two requesters with a timed CE_N access.
// Optional macro PROM_ARB_RR_EN: round-robin arbitration instead of fixed r0 priority.
module prom_access_arbiter #(
  parameter int ADDR_W      = prom_ctl_pkg::ADDR_W,
  parameter int DATA_W      = prom_ctl_pkg::DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_req_valid,
  input  logic [ADDR_W-1:0] r0_req_addr,
  output logic              r0_req_ready,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rsp_data,
  input  logic              r0_rsp_ready,
  input  logic              r1_req_valid,
  input  logic [ADDR_W-1:0] r1_req_addr,
  output logic              r1_req_ready,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rsp_data,
  input  logic              r1_rsp_ready,
  output logic [ADDR_W-1:0] prom_a,
  output logic              prom_ce_n,
  input  logic [DATA_W-1:0] prom_d,
  output logic              busy
);
  import prom_ctl_pkg::*;

  prom_state_e           state_r, state_s;
  logic [WAIT_CNT_W-1:0] cnt_r, cnt_s;
  logic                  owner_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_W-1:0]     r0_data_r, r1_data_r;
  logic                  ce_n_r, ce_n_s;
  logic                  r0_vld_r, r0_vld_s, r1_vld_r, r1_vld_s;
  logic                  busy_r, busy_s;
  logic                  grant0_s, grant1_s, xfer0_s, xfer1_s, xfer_s;

  prom_arb_grant u_grant (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (r0_req_valid),
    .req1    (r1_req_valid),
    .xfer0   (xfer0_s),
    .xfer1   (xfer1_s),
    .grant0  (grant0_s),
    .grant1  (grant1_s)
  );

  assign r0_req_ready = (state_r == IDLE) & grant0_s;
  assign r1_req_ready = (state_r == IDLE) & grant1_s;
  assign xfer0_s      = r0_req_valid & r0_req_ready;
  assign xfer1_s      = r1_req_valid & r1_req_ready;
  assign xfer_s       = xfer0_s | xfer1_s;

  // State, wait counter and access bookkeeping registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= {WAIT_CNT_W{1'b0}};
      owner_r   <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      r0_data_r <= {DATA_W{1'b0}};
      r1_data_r <= {DATA_W{1'b0}};
      ce_n_r    <= 1'b1;
      r0_vld_r  <= 1'b0;
      r1_vld_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      ce_n_r   <= ce_n_s;
      r0_vld_r <= r0_vld_s;
      r1_vld_r <= r1_vld_s;
      busy_r   <= busy_s;
      if (xfer_s) begin
        owner_r <= xfer1_s;
        addr_r  <= xfer1_s ? r1_req_addr : r0_req_addr;
      end else begin
        owner_r <= owner_r;
        addr_r  <= addr_r;
      end
      // Only the owner's byte is updated; the other side keeps its last response.
      if (state_r == CAPTURE && !owner_r) begin
        r0_data_r <= prom_d;
      end else begin
        r0_data_r <= r0_data_r;
      end
      if (state_r == CAPTURE && owner_r) begin
        r1_data_r <= prom_d;
      end else begin
        r1_data_r <= r1_data_r;
      end
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (WAIT_CYCLES == 0) begin
          state_s = CAPTURE;
        end else begin
          state_s = WAIT;
          cnt_s   = WAIT_CNT_W'(WAIT_CYCLES - 1);
        end
      end
      WAIT: begin
        if (cnt_r == {WAIT_CNT_W{1'b0}}) begin
          state_s = CAPTURE;
        end else begin
          cnt_s = cnt_r - WAIT_CNT_W'(1);
        end
      end
      CAPTURE: state_s = RESP;
      RESP: begin
        if (owner_r ? r1_rsp_ready : r0_rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned with the state.
  always_comb begin
    ce_n_s   = !(state_s inside {SETUP, WAIT, CAPTURE});
    r0_vld_s = (state_s == RESP) & ~owner_r;
    r1_vld_s = (state_s == RESP) &  owner_r;
    busy_s   = (state_s != IDLE);
  end

  assign prom_a       = addr_r;
  assign prom_ce_n    = ce_n_r;
  assign r0_rsp_valid = r0_vld_r;
  assign r1_rsp_valid = r1_vld_r;
  assign r0_rsp_data  = r0_data_r;
  assign r1_rsp_data  = r1_data_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_prom_access_arbiter.sv
// Directed bench for prom_access_arbiter: WAIT_CYCLES=2 instance plus a WAIT_CYCLES=0 instance,
// each attached to a 74S472 model (1 ns read delay, contents d = addr ^ 0xA5).
module tb_prom_access_arbiter;

  logic clk = 1'b0;
  logic reset_n;

  logic       r0_req_valid, r1_req_valid, r0_req_ready, r1_req_ready;
  logic [8:0] r0_req_addr, r1_req_addr, prom_a;
  logic       r0_rsp_valid, r1_rsp_valid, r0_rsp_ready, r1_rsp_ready;
  logic [7:0] r0_rsp_data, r1_rsp_data, prom_d;
  logic       prom_ce_n, busy;

  logic       z_r0_req_valid, z_r1_req_valid, z_r0_req_ready, z_r1_req_ready;
  logic [8:0] z_r0_req_addr, z_r1_req_addr, z_prom_a;
  logic       z_r0_rsp_valid, z_r1_rsp_valid, z_r0_rsp_ready, z_r1_rsp_ready;
  logic [7:0] z_r0_rsp_data, z_r1_rsp_data, z_prom_d;
  logic       z_prom_ce_n, z_busy;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [7:0] rom_f(input logic [8:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  assign #1 prom_d   = prom_ce_n   ? 8'hFF : rom_f(prom_a);
  assign #1 z_prom_d = z_prom_ce_n ? 8'hFF : rom_f(z_prom_a);

  always #5 clk = ~clk;

  prom_access_arbiter #(.WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .r0_req_valid(r0_req_valid), .r0_req_addr(r0_req_addr), .r0_req_ready(r0_req_ready),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_data(r0_rsp_data), .r0_rsp_ready(r0_rsp_ready),
    .r1_req_valid(r1_req_valid), .r1_req_addr(r1_req_addr), .r1_req_ready(r1_req_ready),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_data(r1_rsp_data), .r1_rsp_ready(r1_rsp_ready),
    .prom_a(prom_a), .prom_ce_n(prom_ce_n), .prom_d(prom_d), .busy(busy)
  );

  prom_access_arbiter #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .r0_req_valid(z_r0_req_valid), .r0_req_addr(z_r0_req_addr), .r0_req_ready(z_r0_req_ready),
    .r0_rsp_valid(z_r0_rsp_valid), .r0_rsp_data(z_r0_rsp_data), .r0_rsp_ready(z_r0_rsp_ready),
    .r1_req_valid(z_r1_req_valid), .r1_req_addr(z_r1_req_addr), .r1_req_ready(z_r1_req_ready),
    .r1_rsp_valid(z_r1_rsp_valid), .r1_rsp_data(z_r1_rsp_data), .r1_rsp_ready(z_r1_rsp_ready),
    .prom_a(z_prom_a), .prom_ce_n(z_prom_ce_n), .prom_d(z_prom_d), .busy(z_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // r0 read on the WAIT_CYCLES=2 instance with rsp_ready held high.
  task automatic read_r0(input logic [8:0] addr, input logic [7:0] exp_d);
    r0_rsp_ready = 1'b1;
    r0_req_valid = 1'b1;
    r0_req_addr  = addr;
    #1;
    check("r0_req_ready", r0_req_ready, 1'b1);
    tick();
    r0_req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("ce_low_during_access", prom_ce_n, 1'b0);
      check("rsp_not_early", r0_rsp_valid, 1'b0);
      check("prom_a_access", prom_a, addr);
      tick();
    end
    check("rsp_valid_t5", r0_rsp_valid, 1'b1);
    check("rsp_data", r0_rsp_data, exp_d);
    check("ce_high_in_resp", prom_ce_n, 1'b1);
    tick();
    check("rsp_valid_drop", r0_rsp_valid, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("rsp_data_retained", r0_rsp_data, exp_d);
    check("prom_a_held", prom_a, addr);
  endtask

  initial begin
    logic [8:0] last_addr;
    logic       exp_owner;
    int         got;

    reset_n = 1'b0;
    {r0_req_valid, r1_req_valid, r0_rsp_ready, r1_rsp_ready} = 4'b0000;
    {z_r0_req_valid, z_r1_req_valid, z_r0_rsp_ready, z_r1_rsp_ready} = 4'b0000;
    r0_req_addr = 9'h000; r1_req_addr = 9'h000;
    z_r0_req_addr = 9'h000; z_r1_req_addr = 9'h000;
    last_addr = 9'h000;

    repeat (5) tick();
    check("rst_ce_n", prom_ce_n, 1'b1);
    check("rst_prom_a", prom_a, 9'h000);
    check("rst_r0_ready", r0_req_ready, 1'b0);
    check("rst_r1_ready", r1_req_ready, 1'b0);
    check("rst_r0_valid", r0_rsp_valid, 1'b0);
    check("rst_r1_valid", r1_rsp_valid, 1'b0);
    check("rst_r0_data", r0_rsp_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_z_ce_n", z_prom_ce_n, 1'b1);
    reset_n = 1'b1;
    tick();

    read_r0(9'h000, 8'hA5);
    read_r0(9'h1FF, 8'h5A);

    // Both requesters valid every cycle for eight transfers.
    r0_rsp_ready = 1'b1;
    r1_rsp_ready = 1'b1;
    r0_req_valid = 1'b1;
    r1_req_valid = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 8; c++) begin
      r0_req_addr = 9'h010 + 9'(got);
      r1_req_addr = 9'h100 + 9'(got);
      #1;
`ifdef PROM_ARB_RR_EN
      exp_owner = (got % 2 == 0);
`else
      exp_owner = 1'b0;
`endif
      if (r0_req_ready | r1_req_ready) begin
        check("tie_owner", r1_req_ready, exp_owner);
        last_addr = r1_req_ready ? r1_req_addr : r0_req_addr;
        got++;
      end
      if (r0_rsp_valid) check("tie_r0_data", r0_rsp_data, rom_f(last_addr));
      if (r1_rsp_valid) check("tie_r1_data", r1_rsp_data, rom_f(last_addr));
      tick();
    end
    check("tie_count", got, 8);
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    repeat (6) tick();

    // r1 stalls its response; r0 waits without being granted.
    r1_rsp_ready = 1'b0;
    r1_req_valid = 1'b1;
    r1_req_addr  = 9'h0C3;
    #1;
    check("r1_ready_alone", r1_req_ready, 1'b1);
    tick();
    r1_req_valid = 1'b0;
    r0_req_valid = 1'b1;
    r0_req_addr  = 9'h033;
    repeat (4) tick();
    for (int k = 0; k < 10; k++) begin
      check("stall_r1_valid", r1_rsp_valid, 1'b1);
      check("stall_r1_data", r1_rsp_data, 8'h66);
      check("stall_r0_ready", r0_req_ready, 1'b0);
      check("stall_r0_valid", r0_rsp_valid, 1'b0);
      check("stall_busy", busy, 1'b1);
      tick();
    end
    r1_rsp_ready = 1'b1;
    tick();
    check("stall_r1_release", r1_rsp_valid, 1'b0);
    check("stall_r1_data_kept", r1_rsp_data, 8'h66);
    check("stall_r0_granted", r0_req_ready, 1'b1);
    tick();
    r0_req_valid = 1'b0;
    repeat (4) tick();
    check("waited_r0_valid", r0_rsp_valid, 1'b1);
    check("waited_r0_data", r0_rsp_data, 8'h96);
    tick();

    // Reset asserted while the access sits in WAIT.
    r0_req_valid = 1'b1;
    r0_req_addr  = 9'h055;
    tick();
    r0_req_valid = 1'b0;
    tick();
    check("pre_abort_ce_low", prom_ce_n, 1'b0);
    check("pre_abort_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort_ce_high", prom_ce_n, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_prom_a", prom_a, 9'h000);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("abort_no_rsp", r0_rsp_valid, 1'b0);
      check("abort_ce_stays_high", prom_ce_n, 1'b1);
      tick();
    end

    // WAIT_CYCLES=0 instance: CE_N low for exactly two cycles, response at T+3.
    z_r0_rsp_ready = 1'b1;
    z_r0_req_valid = 1'b1;
    z_r0_req_addr  = 9'h1A0;
    #1;
    check("w0_ready", z_r0_req_ready, 1'b1);
    tick();
    z_r0_req_valid = 1'b0;
    check("w0_ce_t1", z_prom_ce_n, 1'b0);
    check("w0_valid_t1", z_r0_rsp_valid, 1'b0);
    tick();
    check("w0_ce_t2", z_prom_ce_n, 1'b0);
    check("w0_valid_t2", z_r0_rsp_valid, 1'b0);
    tick();
    check("w0_ce_t3", z_prom_ce_n, 1'b1);
    check("w0_valid_t3", z_r0_rsp_valid, 1'b1);
    check("w0_data", z_r0_rsp_data, 8'h05);
    tick();
    check("w0_valid_drop", z_r0_rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
